// File: rtl/encoder_priority_8to3.sv
// encoder_priority_8to3: registered 74x148-style 8-to-3 priority encoder, active-low I/O, cascadable via EI/EO/GS
module encoder_priority_8to3 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_in_,
   input  logic [7:0] signal_i_,
   output logic [2:0] signal_o_,
   output logic       group_signal_,
   output logic       enable_out_
);
   logic [2:0] enc;
   logic       any_req;
   // Ascending scan so the highest active index is the last one written
   always_comb begin
      enc = 3'b111;
      for (int i = 0; i < 8; i++)
         if (!signal_i_[i]) enc = ~3'(i);
   end
   assign any_req = ~&signal_i_;
   always_ff @(posedge clk) begin
      if (reset || enable_in_) begin
         signal_o_     <= 3'b111;
         group_signal_ <= 1'b1;
         enable_out_   <= 1'b1;
      end else begin
         signal_o_     <= any_req ? enc : 3'b111;
         group_signal_ <= ~any_req;
         enable_out_   <= any_req;
      end
   end
endmodule

// File: tb/tb_encoder_priority_8to3.sv
// tb_encoder_priority_8to3: randomized and directed checks of the registered priority encoder against a truth-table model
module tb_encoder_priority_8to3;
   logic       clk = 1'b0;
   logic       reset;
   logic       enable_in_;
   logic [7:0] signal_i_;
   logic [2:0] signal_o_;
   logic       group_signal_;
   logic       enable_out_;
   logic       hi_ei_, lo_ei_;
   logic [7:0] hi_sig_, lo_sig_;
   logic [2:0] hi_o_, lo_o_;
   logic       hi_gs_, lo_gs_, lo_eo_;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   encoder_priority_8to3 u_dut (
      .clk(clk), .reset(reset), .enable_in_(enable_in_), .signal_i_(signal_i_),
      .signal_o_(signal_o_), .group_signal_(group_signal_), .enable_out_(enable_out_));

   encoder_priority_8to3 u_hi (
      .clk(clk), .reset(reset), .enable_in_(hi_ei_), .signal_i_(hi_sig_),
      .signal_o_(hi_o_), .group_signal_(hi_gs_), .enable_out_(lo_ei_));

   encoder_priority_8to3 u_lo (
      .clk(clk), .reset(reset), .enable_in_(lo_ei_), .signal_i_(lo_sig_),
      .signal_o_(lo_o_), .group_signal_(lo_gs_), .enable_out_(lo_eo_));

   // Returns {signal_o_, group_signal_, enable_out_} from the 74x148 truth table
   function automatic logic [4:0] model(input logic ei, input logic [7:0] s);
      if (ei) return 5'b11111;
      for (int n = 7; n >= 0; n--)
         if (s[n] == 1'b0) return {~3'(n), 2'b01};
      return 5'b11110;
   endfunction

   task automatic drive_cycle(input logic ei, input logic [7:0] s);
      enable_in_ = ei;
      signal_i_  = s;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      logic [4:0] got;
      reset = 1'b1; enable_in_ = 1'b0; signal_i_ = 8'h00;
      hi_ei_ = 1'b1; hi_sig_ = 8'hFF; lo_sig_ = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); @(negedge clk);
         got = {signal_o_, group_signal_, enable_out_};
         checks++;
         if (got !== 5'b11111) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got=%b exp=11111", c, got);
         end
      end
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      got = {signal_o_, group_signal_, enable_out_};
      checks++;
      if (got !== 5'b00001) begin
         failures++;
         $display("FAIL reset_release got=%b exp=00001", got);
      end
   endtask

   task automatic test_directed;
      logic [8:0]  vec [7] = '{9'h100, 9'h0FF, 9'h07F, 9'h0BF, 9'h0F7, 9'h0FE, 9'h000};
      logic [4:0]  exp [7] = '{5'b11111, 5'b11110, 5'b00001, 5'b00101, 5'b10001, 5'b11101, 5'b00001};
      logic [4:0]  got;
      for (int k = 0; k < 7; k++) begin
         drive_cycle(vec[k][8], vec[k][7:0]);
         got = {signal_o_, group_signal_, enable_out_};
         checks++;
         if (got !== exp[k]) begin
            failures++;
            $display("FAIL directed ei=%b sig=%h got=%b exp=%b", vec[k][8], vec[k][7:0], got, exp[k]);
         end
      end
   endtask

   task automatic test_sweep;
      logic [4:0] got, exp;
      for (int v = 0; v < 256; v++) begin
         drive_cycle(1'b0, 8'(v));
         got = {signal_o_, group_signal_, enable_out_};
         exp = model(1'b0, 8'(v));
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL sweep sig=%h got=%b exp=%b", v[7:0], got, exp);
         end
         checks++;
         if (!group_signal_ && !enable_out_) begin
            failures++;
            $display("FAIL gs_eo_both_low sig=%h gs=%b eo=%b req=not_both_0", v[7:0], group_signal_, enable_out_);
         end
      end
   endtask

   task automatic test_random;
      logic [4:0] got, exp;
      logic       ei, rst;
      logic [7:0] s;
      for (int k = 0; k < 400; k++) begin
         ei  = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 15) == 0);
         s   = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'hFF << $urandom_range(0, 8);
         reset = rst;
         drive_cycle(ei, s);
         got = {signal_o_, group_signal_, enable_out_};
         exp = rst ? 5'b11111 : model(ei, s);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL random rst=%b ei=%b sig=%h got=%b exp=%b", rst, ei, s, got, exp);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_cascade;
      logic [3:0]  idx;
      logic [15:0] w;
      int          exp_idx;
      logic        exp_any;
      hi_ei_ = 1'b0; hi_sig_ = 8'hFF; lo_sig_ = 8'hEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({lo_o_, lo_gs_, lo_eo_} !== 5'b01101) begin
         failures++;
         $display("FAIL cascade_low got=%b exp=01101", {lo_o_, lo_gs_, lo_eo_});
      end
      idx = ~{hi_gs_, hi_o_ & lo_o_};
      checks++;
      if (idx !== 4'd4) begin
         failures++;
         $display("FAIL cascade_index got=%0d exp=4", idx);
      end
      for (int k = 0; k < 40; k++) begin
         w = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFF << $urandom_range(0, 16);
         hi_sig_ = w[15:8]; lo_sig_ = w[7:0];
         repeat (3) @(posedge clk);
         @(negedge clk);
         exp_any = 1'b0; exp_idx = 0;
         for (int n = 15; n >= 0; n--)
            if (!exp_any && !w[n]) begin exp_any = 1'b1; exp_idx = n; end
         idx = ~{hi_gs_, hi_o_ & lo_o_};
         checks++;
         if ((hi_gs_ & lo_gs_) !== ~exp_any || (exp_any && idx !== 4'(exp_idx)) || lo_eo_ !== exp_any) begin
            failures++;
            $display("FAIL cascade_rand w=%h gs=%b idx=%0d eo=%b exp_any=%b exp_idx=%0d",
                     w, hi_gs_ & lo_gs_, idx, lo_eo_, exp_any, exp_idx);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] got;
      drive_cycle(1'b0, 8'hFE);
      reset = 1'b1;
      drive_cycle(1'b0, 8'h00);
      got = {signal_o_, group_signal_, enable_out_};
      checks++;
      if (got !== 5'b11111) begin
         failures++;
         $display("FAIL midop_reset got=%b exp=11111", got);
      end
      reset = 1'b0;
      drive_cycle(1'b0, 8'hFE);
      got = {signal_o_, group_signal_, enable_out_};
      checks++;
      if (got !== 5'b11101) begin
         failures++;
         $display("FAIL after_midop_reset got=%b exp=11101", got);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_sweep;
      test_random;
      test_cascade;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/encoder_priority_8to3.md
Name: encoder_priority_8to3

Overview:
- 8-to-3 priority encoder with active-low inputs and outputs, functionally equivalent to a 74x148.
- Supports cascading through an enable-in / enable-out / group-signal chain.
- Outputs are registered on the single system clock.
- Used as the encoder leaf in the lab datapath; wider encoders are built by chaining enable_out_ into the enable_in_ of a lower-priority stage.

Parameters:
- none (fixed 8-to-3 width)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- enable_in_  input  1  active-low enable (EI); 1 = encoder disabled
- signal_i_  input  8  active-low request lines; bit 7 = highest priority, bit 0 = lowest
- signal_o_  output  3  active-low encoded index of the highest-priority active request (A2..A0)
- group_signal_  output  1  active-low group select (GS); 0 = enabled and at least one request active
- enable_out_  output  1  active-low enable out (EO); 0 = enabled and no request active (cascade to next stage)

Behaviour:
- All three outputs are registered. Each rising clk edge captures the combinational encode of the current enable_in_ and signal_i_.
- Latency is exactly 1 cycle. No handshake.
- Reset (synchronous, active-high, highest priority) loads the disabled state: signal_o_=3'b111, group_signal_=1, enable_out_=1.
- When reset is deasserted, the outputs are updated on every edge per the truth table below. There is no other state.
- Disabled (enable_in_=1), regardless of signal_i_: signal_o_=111, group_signal_=1, enable_out_=1.
- Enabled (enable_in_=0) and signal_i_=8'hFF (no request): signal_o_=111, group_signal_=1, enable_out_=0.
- Enabled and at least one bit of signal_i_ is 0:
  - n = highest index with signal_i_[n]=0.
  - signal_o_ = ~n (3-bit bitwise inverse), group_signal_=0, enable_out_=1.
  - Lower-priority request bits are ignored.
- Boundaries:
  - n=7 gives signal_o_=000; n=0 gives signal_o_=111 with group_signal_=0. group_signal_ is what distinguishes "input 0 active" from "idle".
  - group_signal_ and enable_out_ are never both 0.
- X/Z on inputs is not handled specially; the bench drives only known values.
- Reset asserted mid-operation forces the reset values on the next edge, whatever the inputs.

Test Plan:
- Reset: assert reset for 2 cycles with enable_in_=0, signal_i_=8'h00 -> outputs read 111/1/1; after release, the next edge gives 000/0/1.
- Disable: enable_in_=1, signal_i_=8'h00 -> one cycle later signal_o_=111, group_signal_=1, enable_out_=1.
- Idle enabled: enable_in_=0, signal_i_=8'hFF -> one cycle later 111/1/0.
- Priority picks:
  - 8'h7F -> 000/0/1
  - 8'hBF -> 001/0/1
  - 8'hF7 -> 100/0/1
  - 8'hFE -> 111/0/1
  - 8'h00 -> 000/0/1 (bit 7 dominates)
- Exhaustive sweep: enable_in_=0, signal_i_ stepping 8'h00..8'hFF one value per cycle -> every registered output matches the truth table applied to the previous cycle's input. No cycle may have group_signal_=0 and enable_out_=0 together.
- Cascade: two instances, with the high instance's enable_out_ driving the low instance's enable_in_.
  - High stage requests 8'hFF, low stage 8'hEF -> low stage outputs 011/0/1.
  - Combined 4-bit index (high GS as MSB) decodes to input 4.
